// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

  localparam int ADDR_W_DEF = 5;

  // Operand source select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result
  localparam logic [1:0] FWD_WBQ = 2'b11;  // registered previous writeback

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// Priority forwarding comparator for one EX-stage read port.
// Latency: combinational.
// Backpressure: none; pure function of the current stage addresses.
//
// Ports: ex_raddr_i/ex_rvalid_i - the port's source register and read enable;
//        exmem_*, memwb_*, wbq_*    - candidate producers, nearest first;
//        sel_o                      - chosen source (FWD_* encoding).
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WB_BYPASS = 1
) (
  input  logic [ADDR_W-1:0] ex_raddr_i,
  input  logic              ex_rvalid_i,
  input  logic [ADDR_W-1:0] exmem_waddr_i,
  input  logic              exmem_regwrite_i,
  input  logic [ADDR_W-1:0] memwb_waddr_i,
  input  logic              memwb_regwrite_i,
  input  logic [ADDR_W-1:0] wbq_addr_i,
  input  logic              wbq_valid_i,
  output logic [1:0]        sel_o
);

  logic hit_mem;
  logic hit_wb;
  logic hit_wbq;

  // r0 is hardwired zero, so a write to it is never a real producer.
  assign hit_mem = ex_rvalid_i && exmem_regwrite_i && (exmem_waddr_i != '0)
                   && (exmem_waddr_i == ex_raddr_i);
  assign hit_wb  = ex_rvalid_i && memwb_regwrite_i && (memwb_waddr_i != '0)
                   && (memwb_waddr_i == ex_raddr_i);
  assign hit_wbq = (WB_BYPASS != 0) && ex_rvalid_i && wbq_valid_i
                   && (wbq_addr_i != '0) && (wbq_addr_i == ex_raddr_i);

  // Youngest producer wins.
  always_comb begin
    sel_o = FWD_RF;
    if (hit_mem)      sel_o = FWD_MEM;
    else if (hit_wb)  sel_o = FWD_WB;
    else if (hit_wbq) sel_o = FWD_WBQ;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select plus load-use stall control for the 5-stage pipe.
// Latency: selects/stall are combinational; stall length set by LOAD_STALL_CYC.
// Backpressure: mem_stall_i freezes every internal register and raises pipe_hold_o.
//
// Ports: id_* - IF/ID operand reads (hazard detect); ex_* - ID/EX operand reads
//        (forwarding); idex_/exmem_/memwb_* - stage destinations; flush_i squashes
//        IF/ID; fwd_sel_o per-port select; stall_o/bubble_o/pipe_hold_o pipeline
//        control; stall_cnt_o saturating load-use stall cycle count.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NUM_RD_PORTS   = 2,
  parameter int LOAD_STALL_CYC = 1,
  parameter int WB_BYPASS      = 1,
  parameter int CNT_W          = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] id_raddr_i,
  input  logic [NUM_RD_PORTS-1:0]        id_rvalid_i,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] ex_raddr_i,
  input  logic [NUM_RD_PORTS-1:0]        ex_rvalid_i,
  input  logic [ADDR_W-1:0]              idex_waddr_i,
  input  logic                           idex_regwrite_i,
  input  logic                           idex_memread_i,
  input  logic [ADDR_W-1:0]              exmem_waddr_i,
  input  logic                           exmem_regwrite_i,
  input  logic [ADDR_W-1:0]              memwb_waddr_i,
  input  logic                           memwb_regwrite_i,
  input  logic                           mem_stall_i,
  input  logic                           flush_i,
  output logic [2*NUM_RD_PORTS-1:0]      fwd_sel_o,
  output logic                           stall_o,
  output logic                           bubble_o,
  output logic                           pipe_hold_o,
  output logic [CNT_W-1:0]               stall_cnt_o
);

  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYC - 1);

  state_e            state_q, state_d;
  logic [2:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wbq_addr_q, wbq_addr_d;
  logic              wbq_valid_q, wbq_valid_d;

  logic [2*NUM_RD_PORTS-1:0] fwd_raw;
  logic                      hazard;
  logic                      stall_raw;

  // ---------------- forwarding ----------------
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .ADDR_W    (ADDR_W),
      .WB_BYPASS (WB_BYPASS)
    ) u_sel (
      .ex_raddr_i       (ex_raddr_i[p*ADDR_W +: ADDR_W]),
      .ex_rvalid_i      (ex_rvalid_i[p]),
      .exmem_waddr_i    (exmem_waddr_i),
      .exmem_regwrite_i (exmem_regwrite_i),
      .memwb_waddr_i    (memwb_waddr_i),
      .memwb_regwrite_i (memwb_regwrite_i),
      .wbq_addr_i       (wbq_addr_q),
      .wbq_valid_i      (wbq_valid_q),
      .sel_o            (fwd_raw[2*p +: 2])
    );
  end

  assign fwd_sel_o = rst_i ? '0 : fwd_raw;

  // ---------------- load-use detect ----------------
  always_comb begin
    hazard = 1'b0;
    if (idex_memread_i && idex_regwrite_i && (idex_waddr_i != '0)) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (id_rvalid_i[p] && (id_raddr_i[p*ADDR_W +: ADDR_W] == idex_waddr_i))
          hazard = 1'b1;
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!mem_stall_i) begin
      unique case (state_q)
        RUN: begin
          if (hazard && !flush_i) begin
            rem_d   = REM_INIT;
            state_d = (LOAD_STALL_CYC > 1) ? LU_STALL : RUN;
          end
        end
        LU_STALL: begin
          // A squashed IF/ID instruction no longer needs its operand.
          if (flush_i) begin
            rem_d   = '0;
            state_d = RUN;
          end else begin
            rem_d = rem_q - 3'd1;
            if (rem_q == 3'd1) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall_raw = 1'b0;
    unique case (state_q)
      RUN:      stall_raw = !mem_stall_i && hazard && !flush_i;
      LU_STALL: stall_raw = 1'b1;
      default:  stall_raw = 1'b0;
    endcase
  end

  assign stall_o     = !rst_i && stall_raw;
  assign bubble_o    = !rst_i && stall_raw;
  assign pipe_hold_o = !rst_i && mem_stall_i;
  assign stall_cnt_o = cnt_q;

  // ---------------- wbq and statistics ----------------
  always_comb begin
    wbq_addr_d  = wbq_addr_q;
    wbq_valid_d = wbq_valid_q;
    cnt_d       = cnt_q;
    if (!mem_stall_i) begin
      wbq_addr_d  = memwb_waddr_i;
      wbq_valid_d = memwb_regwrite_i;
      if (stall_raw && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      rem_q       <= '0;
      cnt_q       <= '0;
      wbq_addr_q  <= '0;
      wbq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      wbq_addr_q  <= wbq_addr_d;
      wbq_valid_q <= wbq_valid_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: two instances share stimulus.
// Instance A: LOAD_STALL_CYC=3, WB_BYPASS=1, CNT_W=16.
// Instance B: LOAD_STALL_CYC=1, WB_BYPASS=0, CNT_W=2.
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NP = 2;

  typedef enum int {S_FWDA, S_STA, S_BUBA, S_HOLDA, S_CNTA, S_FWDB, S_STB, S_HOLDB, S_CNTB} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } item_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [NP*AW-1:0] id_raddr_i, ex_raddr_i;
  logic [NP-1:0]    id_rvalid_i, ex_rvalid_i;
  logic [AW-1:0]    idex_waddr_i, exmem_waddr_i, memwb_waddr_i;
  logic idex_regwrite_i, idex_memread_i, exmem_regwrite_i, memwb_regwrite_i;
  logic mem_stall_i, flush_i;

  logic [2*NP-1:0] fwd_a, fwd_b;
  logic stall_a, bub_a, hold_a, stall_b, bub_b, hold_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  item_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit #(.ADDR_W(AW), .NUM_RD_PORTS(NP), .LOAD_STALL_CYC(3),
                    .WB_BYPASS(1), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_raddr_i(id_raddr_i), .id_rvalid_i(id_rvalid_i),
    .ex_raddr_i(ex_raddr_i), .ex_rvalid_i(ex_rvalid_i),
    .idex_waddr_i(idex_waddr_i), .idex_regwrite_i(idex_regwrite_i),
    .idex_memread_i(idex_memread_i),
    .exmem_waddr_i(exmem_waddr_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_waddr_i(memwb_waddr_i), .memwb_regwrite_i(memwb_regwrite_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .fwd_sel_o(fwd_a), .stall_o(stall_a), .bubble_o(bub_a),
    .pipe_hold_o(hold_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_unit #(.ADDR_W(AW), .NUM_RD_PORTS(NP), .LOAD_STALL_CYC(1),
                    .WB_BYPASS(0), .CNT_W(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_raddr_i(id_raddr_i), .id_rvalid_i(id_rvalid_i),
    .ex_raddr_i(ex_raddr_i), .ex_rvalid_i(ex_rvalid_i),
    .idex_waddr_i(idex_waddr_i), .idex_regwrite_i(idex_regwrite_i),
    .idex_memread_i(idex_memread_i),
    .exmem_waddr_i(exmem_waddr_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_waddr_i(memwb_waddr_i), .memwb_regwrite_i(memwb_regwrite_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .fwd_sel_o(fwd_b), .stall_o(stall_b), .bubble_o(bub_b),
    .pipe_hold_o(hold_b), .stall_cnt_o(cnt_b)
  );

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_FWDA:  return 32'(fwd_a);
      S_STA:   return 32'(stall_a);
      S_BUBA:  return 32'(bub_a);
      S_HOLDA: return 32'(hold_a);
      S_CNTA:  return 32'(cnt_a);
      S_FWDB:  return 32'(fwd_b);
      S_STB:   return 32'(stall_b);
      S_HOLDB: return 32'(hold_b);
      S_CNTB:  return 32'(cnt_b);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_v(input string tag, input sig_e s, input logic [31:0] v);
    item_t it;
    it.tag = tag; it.sig = s; it.exp = v;
    sb.push_back(it);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic chk();
    item_t it;
    logic [31:0] o;
    #2;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o = observe(it.sig);
      checks++;
      assert (o === it.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_raddr_i = '0; id_rvalid_i = '0; ex_raddr_i = '0; ex_rvalid_i = '0;
    idex_waddr_i = '0; idex_regwrite_i = 0; idex_memread_i = 0;
    exmem_waddr_i = '0; exmem_regwrite_i = 0;
    memwb_waddr_i = '0; memwb_regwrite_i = 0;
    mem_stall_i = 0; flush_i = 0;
  endtask

  // Load to r5 in ID/EX with IF/ID port1 reading r5.
  task automatic set_haz(input bit on);
    idex_waddr_i    = on ? 5'd5 : 5'd0;
    idex_memread_i  = on;
    idex_regwrite_i = on;
    id_raddr_i      = on ? {5'd5, 5'd0} : '0;
    id_rvalid_i     = on ? 2'b10 : 2'b00;
  endtask

  task automatic exp_a(input string tag, input logic st, input logic [15:0] cnt);
    expect_v({tag, "_stall"}, S_STA, 32'(st));
    expect_v({tag, "_bubble"}, S_BUBA, 32'(st));
    expect_v({tag, "_cnt"}, S_CNTA, 32'(cnt));
  endtask

  initial begin
    // Reset active, before any edge: drive conflicting activity, outputs must be 0.
    idle();
    rst_i = 1;
    set_haz(1);
    mem_stall_i = 1;
    exmem_waddr_i = 5'd3; exmem_regwrite_i = 1;
    ex_raddr_i = {5'd0, 5'd3}; ex_rvalid_i = 2'b01;
    expect_v("rst_fwd", S_FWDA, 32'h0);
    expect_v("rst_stall", S_STA, 32'h0);
    expect_v("rst_bubble", S_BUBA, 32'h0);
    expect_v("rst_hold", S_HOLDA, 32'h0);
    chk();
    tick(); tick();
    idle();
    expect_v("rst_cnt_a", S_CNTA, 32'h0);
    expect_v("rst_cnt_b", S_CNTB, 32'h0);
    chk();
    rst_i = 0;

    // EX/MEM and MEM/WB both write r3 -> EX/MEM wins; then MEM/WB.
    exmem_waddr_i = 5'd3; exmem_regwrite_i = 1;
    memwb_waddr_i = 5'd3; memwb_regwrite_i = 1;
    ex_raddr_i = {5'd0, 5'd3}; ex_rvalid_i = 2'b01;
    expect_v("fwd_mem", S_FWDA, 32'h2);
    expect_v("fwd_mem_b", S_FWDB, 32'h2);
    chk();
    exmem_regwrite_i = 0;
    expect_v("fwd_wb", S_FWDA, 32'h1);
    chk();
    ex_rvalid_i = 2'b00;
    expect_v("fwd_norvalid", S_FWDA, 32'h0);
    chk();

    // r0 writes everywhere never forward.
    tick();
    exmem_waddr_i = 5'd0; exmem_regwrite_i = 1;
    memwb_waddr_i = 5'd0; memwb_regwrite_i = 1;
    ex_raddr_i = '0; ex_rvalid_i = 2'b11;
    expect_v("fwd_r0", S_FWDA, 32'h0);
    chk();

    // Registered writeback: MEM/WB writes r7, next cycle both ports read r7.
    tick();
    idle();
    memwb_waddr_i = 5'd7; memwb_regwrite_i = 1;
    ex_raddr_i = {5'd9, 5'd9}; ex_rvalid_i = 2'b11;
    expect_v("wbq_prev", S_FWDA, 32'h0);
    chk();
    tick();
    idle();
    ex_raddr_i = {5'd7, 5'd7}; ex_rvalid_i = 2'b11;
    expect_v("wbq_a", S_FWDA, 32'hF);
    expect_v("wbq_b_off", S_FWDB, 32'h0);
    chk();

    // Load-use, 3-cycle stall on A, 1-cycle on B.
    tick();
    idle();
    set_haz(1);
    exp_a("lu0", 1, 0);
    expect_v("lu0_stall_b", S_STB, 32'h1);
    chk();
    tick(); set_haz(0);
    exp_a("lu1", 1, 1);
    expect_v("lu1_stall_b", S_STB, 32'h0);
    expect_v("lu1_cnt_b", S_CNTB, 32'h1);
    chk();
    tick();
    exp_a("lu2", 1, 2);
    chk();
    tick();
    exp_a("lu3", 0, 3);
    chk();

    // Load-use with mem_stall held 4 cycles mid-stall.
    tick();
    set_haz(1);
    exp_a("ms0", 1, 3);
    chk();
    tick(); set_haz(0);
    exp_a("ms1", 1, 4);
    expect_v("ms1_hold", S_HOLDA, 32'h0);
    chk();
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_stall_i = 1;
      exp_a("ms_frz", 1, 5);
      expect_v("ms_frz_hold", S_HOLDA, 32'h1);
      expect_v("ms_frz_hold_b", S_HOLDB, 32'h1);
      expect_v("ms_frz_stall_b", S_STB, 32'h0);
      chk();
    end
    tick();
    mem_stall_i = 0;
    exp_a("ms6", 1, 5);
    expect_v("ms6_hold", S_HOLDA, 32'h0);
    chk();
    tick();
    exp_a("ms7", 0, 6);
    expect_v("ms7_cnt_b", S_CNTB, 32'h2);
    chk();

    // Hazard with flush ignored.
    tick();
    set_haz(1); flush_i = 1;
    exp_a("fl_haz", 0, 6);
    expect_v("fl_haz_b", S_STB, 32'h0);
    chk();
    tick();
    set_haz(0); flush_i = 0;
    exp_a("fl_haz_after", 0, 6);
    chk();

    // Flush during LU_STALL returns to RUN on the next edge.
    set_haz(1);
    exp_a("fs0", 1, 6);
    chk();
    tick();
    set_haz(0); flush_i = 1;
    exp_a("fs1", 1, 7);
    chk();
    tick();
    flush_i = 0;
    exp_a("fs2", 0, 8);
    expect_v("fs2_cnt_b", S_CNTB, 32'h3);
    chk();

    // Two more B stall cycles: the 2-bit counter must hold at 3.
    set_haz(1);
    expect_v("sat0_stall_b", S_STB, 32'h1);
    chk();
    tick();
    expect_v("sat1_stall_b", S_STB, 32'h1);
    expect_v("sat1_cnt_b", S_CNTB, 32'h3);
    exp_a("sat1", 1, 9);
    chk();
    tick();
    set_haz(0);
    expect_v("sat2_cnt_b", S_CNTB, 32'h3);
    expect_v("sat2_stall_b", S_STB, 32'h0);
    exp_a("sat2", 1, 10);
    chk();
    tick();
    expect_v("sat3_cnt_b", S_CNTB, 32'h3);
    exp_a("sat3", 0, 11);
    chk();

    // Reset mid-stall aborts it.
    set_haz(1);
    chk();
    tick();
    set_haz(0);
    rst_i = 1;
    expect_v("rmid_stall", S_STA, 32'h0);
    chk();
    tick();
    rst_i = 0;
    exp_a("rmid_after", 0, 0);
    chk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard-control unit for the 5-stage pipeline.
- Selects the operand source for every EX-stage read port from four places: the EX/MEM result, the MEM/WB result, a registered copy of the previous writeback, or the register file.
- Detects load-use hazards in ID and holds a programmable-length stall through a small FSM.
- Freezes all internal state while the dcache signals a memory stall. Exposes a saturating stall-cycle counter.

Parameters:
ADDR_W, 5, register address width
NUM_RD_PORTS, 2, number of operand read ports per instruction
LOAD_STALL_CYC, 1, bubble cycles inserted per load-use hazard (range 1..7)
WB_BYPASS, 1, 1 enables the registered-writeback source (sel 2'b11); 0 never produces it
CNT_W, 16, width of the stall statistics counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_raddr_i  in  NUM_RD_PORTS*ADDR_W  IF/ID source addresses; port p at [p*ADDR_W +: ADDR_W]
id_rvalid_i  in  NUM_RD_PORTS  IF/ID port p actually reads its register
ex_raddr_i  in  NUM_RD_PORTS*ADDR_W  ID/EX source addresses
ex_rvalid_i  in  NUM_RD_PORTS  ID/EX port p actually reads its register
idex_waddr_i  in  ADDR_W  ID/EX destination
idex_regwrite_i  in  1  ID/EX writes a register
idex_memread_i  in  1  ID/EX is a load
exmem_waddr_i  in  ADDR_W  EX/MEM destination
exmem_regwrite_i  in  1  EX/MEM writes a register
memwb_waddr_i  in  ADDR_W  MEM/WB destination
memwb_regwrite_i  in  1  MEM/WB writes a register
mem_stall_i  in  1  dcache busy; whole pipeline frozen
flush_i  in  1  IF/ID instruction squashed (branch/jump)
fwd_sel_o  out  2*NUM_RD_PORTS  per-port source select; port p at [2p+1:2p]
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  load NOP into ID/EX
pipe_hold_o  out  1  freeze all pipeline registers
stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_i high at a clock edge):
  - FSM to RUN, stall counter to 0, remaining-cycle counter to 0, wbq_valid to 0.
  - Combinational outputs during reset: stall_o=0, bubble_o=0, pipe_hold_o=0, fwd_sel_o=0.
- Reset mid-stall aborts the stall on the next edge.

Forwarding (combinational, per port p, first match wins):
1. ex_rvalid_i[p], exmem_regwrite_i, exmem_waddr_i!=0, exmem_waddr_i==ex_raddr[p] -> 2'b10.
2. Same test against memwb_* -> 2'b01.
3. WB_BYPASS=1, wbq_valid, wbq_addr!=0, wbq_addr==ex_raddr[p] -> 2'b11.
4. Otherwise -> 2'b00.
- Address 0 never matches.

wbq register:
- On each edge with !mem_stall_i and !rst_i: wbq_addr<=memwb_waddr_i, wbq_valid<=memwb_regwrite_i.
- Held while mem_stall_i.

Load-use hazard (combinational):
- Asserted when idex_memread_i & idex_regwrite_i & idex_waddr_i!=0, and some port p has id_rvalid_i[p] with id_raddr[p]==idex_waddr_i.

FSM states: RUN, LU_STALL.
- pipe_hold_o = mem_stall_i, in every state.
- RUN:
  - If mem_stall_i: outputs 0 except pipe_hold_o, state held.
  - Else if hazard & !flush_i: stall_o=1, bubble_o=1, remaining<=LOAD_STALL_CYC-1.
    - Next state is LU_STALL if LOAD_STALL_CYC>1, else RUN.
  - A hazard with flush_i=1 is ignored.
- LU_STALL:
  - stall_o=1, bubble_o=1 every cycle.
  - remaining decrements on each edge with !mem_stall_i.
  - Returns to RUN on the edge where remaining==1 is consumed.
  - flush_i=1 -> RUN on the next edge; stall_o/bubble_o stay 1 in the flush cycle.
  - mem_stall_i freezes remaining and state; stall_o and bubble_o stay asserted.
- Total bubbles per hazard = LOAD_STALL_CYC cycles excluding mem-stall cycles.

Stall counter:
- Increments by 1 on each edge where stall_o=1 and !mem_stall_i.
- Saturates at all-ones and never wraps.

Decomposition:
- Shared package fwd_pkg holds:
  - select encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_WBQ=2'b11;
  - FSM state enum {RUN, LU_STALL};
  - the ADDR_W default.
- One sub-module, fwd_port_sel: the priority comparator for a single port, instantiated NUM_RD_PORTS times in a generate loop.
- The FSM, wbq register and counters stay in the top level.

Test Plan:
- EX/MEM and MEM/WB both write r3; ex_raddr port0=3 -> fwd_sel_o[1:0]=2'b10. Drop exmem_regwrite_i -> 2'b01.
- Writes to r0 in every stage with ex_raddr=0 -> fwd_sel_o=0. After reset, before any edge, all outputs are 0.
- Load r5 in ID/EX, id_raddr port1=5, LOAD_STALL_CYC=3 -> stall_o=bubble_o=1 for exactly 3 cycles, then stall_cnt_o=3.
- Repeat the load-use case with mem_stall_i held 4 cycles mid-stall -> stall lasts 7 cycles, pipe_hold_o high for 4 of them, stall_cnt_o=3.
- MEM/WB writes r7, next cycle ex_raddr port0=7 with no stage match -> 2'b11. With WB_BYPASS=0 -> 2'b00.
- Hazard with flush_i=1 -> no stall. flush_i during LU_STALL -> RUN next edge.
- Force CNT_W=2 with 5 stall cycles -> stall_cnt_o stays at 3.
